// File: rtl/lcd_ctrl.sv
// HD44780 write controller: SETUP/PULSE/HOLD/EXEC timing from a single down-counter.
// Define LCD_INIT_EN to build the power-up wait and the built-in init sequence.
module lcd_ctrl #(
   parameter int unsigned SETUP_CYC    = 2,
   parameter int unsigned EN_CYC       = 12,
   parameter int unsigned HOLD_CYC     = 2,
   parameter int unsigned EXEC_CYC     = 2000,
   parameter int unsigned CLR_EXEC_CYC = 82000,
   parameter int unsigned PWRUP_CYC    = 750000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_vld,
   input  logic        i_req_rs,
   input  logic [7:0]  i_req_data,
   output logic        o_req_rdy,
   output logic        o_lcd_on,
   output logic        o_lcd_en,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic [7:0]  o_lcd_data,
   output logic [31:0] o_lcd_word,
   output logic        o_busy
);

   function automatic int unsigned at_least_1(input int unsigned v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned SETUP_N = at_least_1(SETUP_CYC);
   localparam int unsigned EN_N    = at_least_1(EN_CYC);
   localparam int unsigned HOLD_N  = at_least_1(HOLD_CYC);
   localparam int unsigned EXEC_N  = at_least_1(EXEC_CYC);
   localparam int unsigned CLR_N   = at_least_1(CLR_EXEC_CYC);
   localparam int unsigned PWRUP_N = at_least_1(PWRUP_CYC);
   localparam int unsigned MAX_N   = max2(max2(max2(SETUP_N, EN_N), max2(HOLD_N, EXEC_N)),
                                          max2(CLR_N, PWRUP_N));
   localparam int unsigned CNT_W   = (MAX_N > 1) ? $clog2(MAX_N) : 1;

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_N - 1);
   localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_N - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_N - 1);
   localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_N - 1);
   localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_N - 1);

   typedef enum logic [2:0] {
`ifdef LCD_INIT_EN
      INIT_WAIT,
      INIT_SEND,
`endif
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      EXEC
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             is_clr;

`ifdef LCD_INIT_EN
   localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_N - 1);
   logic [1:0] init_idx;
   logic       init_done;
   logic       pwr_armed;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction
`endif

   // Clear/Home need the long execution wait; uses the latched command byte.
   assign is_clr = !o_lcd_rs && (o_lcd_data[7:2] == '0) && (o_lcd_data[1:0] != 2'b00);

   assign o_lcd_rw   = 1'b0;
   assign o_lcd_word = {o_lcd_on, 20'b0, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
`ifdef LCD_INIT_EN
         state     <= INIT_WAIT;
         init_idx  <= '0;
         init_done <= 1'b0;
         pwr_armed <= 1'b0;
`else
         state     <= IDLE;
`endif
         cnt        <= '0;
         o_lcd_en   <= 1'b0;
         o_lcd_rs   <= 1'b0;
         o_lcd_data <= '0;
         o_lcd_on   <= 1'b0;
         o_req_rdy  <= 1'b0;
         o_busy     <= 1'b1;
      end else begin
         o_lcd_on <= 1'b1;
         case (state)
`ifdef LCD_INIT_EN
            // Counter is cleared by reset, so the first INIT_WAIT cycle arms it.
            INIT_WAIT: begin
               if (!pwr_armed) begin
                  pwr_armed <= 1'b1;
                  cnt       <= PWRUP_LD;
               end else if (cnt == '0) begin
                  state <= INIT_SEND;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            INIT_SEND: begin
               o_lcd_rs   <= 1'b0;
               o_lcd_data <= init_cmd(init_idx);
               cnt        <= SETUP_LD;
               state      <= SETUP;
            end
`endif
            IDLE: begin
               if (i_req_vld && o_req_rdy) begin
                  o_lcd_rs   <= i_req_rs;
                  o_lcd_data <= i_req_data;
                  o_req_rdy  <= 1'b0;
                  o_busy     <= 1'b1;
                  cnt        <= SETUP_LD;
                  state      <= SETUP;
               end else begin
                  o_req_rdy <= 1'b1;
                  o_busy    <= 1'b0;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  o_lcd_en <= 1'b1;
                  cnt      <= EN_LD;
                  state    <= PULSE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            PULSE: begin
               if (cnt == '0) begin
                  o_lcd_en <= 1'b0;
                  cnt      <= HOLD_LD;
                  state    <= HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  cnt   <= is_clr ? CLR_LD : EXEC_LD;
                  state <= EXEC;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
`ifdef LCD_INIT_EN
               end else if (!init_done && (init_idx != 2'd3)) begin
                  init_idx <= init_idx + 1'b1;
                  state    <= INIT_SEND;
`endif
               end else begin
`ifdef LCD_INIT_EN
                  init_done <= 1'b1;
`endif
                  o_req_rdy <= 1'b1;
                  o_busy    <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: randomized writes, expected transfers queued at handshake,
// monitor checks each EN pulse, bus stability, latency and output packing.
module tb_lcd_ctrl;

   localparam int unsigned P_SETUP = 2;
   localparam int unsigned P_EN    = 3;
   localparam int unsigned P_HOLD  = 2;
   localparam int unsigned P_EXEC  = 5;
   localparam int unsigned P_CLR   = 9;
   localparam int unsigned P_PWRUP = 4;

`ifdef LCD_INIT_EN
   localparam bit INIT_MODE = 1'b1;
`else
   localparam bit INIT_MODE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_vld = 1'b0;
   logic        req_rs = 1'b0;
   logic [7:0]  req_data = '0;
   logic        req_rdy;
   logic        lcd_on;
   logic        lcd_en;
   logic        lcd_rs;
   logic        lcd_rw;
   logic [7:0]  lcd_data;
   logic [31:0] lcd_word;
   logic        busy;

   lcd_ctrl #(
      .SETUP_CYC(P_SETUP),
      .EN_CYC(P_EN),
      .HOLD_CYC(P_HOLD),
      .EXEC_CYC(P_EXEC),
      .CLR_EXEC_CYC(P_CLR),
      .PWRUP_CYC(P_PWRUP)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_req_vld(req_vld),
      .i_req_rs(req_rs),
      .i_req_data(req_data),
      .o_req_rdy(req_rdy),
      .o_lcd_on(lcd_on),
      .o_lcd_en(lcd_en),
      .o_lcd_rs(lcd_rs),
      .o_lcd_rw(lcd_rw),
      .o_lcd_data(lcd_data),
      .o_lcd_word(lcd_word),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         hs;   // sample index of the handshake, -1 for internally issued commands
      int         lat;  // expected handshake-to-rdy cycles
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ncyc = 0;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   // Expected request-to-rdy time from the write timing rules.
   function automatic int exp_lat(input logic rs, input logic [7:0] d);
      int ex;
      ex = (!rs && d >= 8'h01 && d <= 8'h03) ? int'(P_CLR) : int'(P_EXEC);
      return int'(P_SETUP + P_EN + P_HOLD) + ex + 1;
   endfunction

   task automatic push_init_cmds();
`ifdef LCD_INIT_EN
      exp_q.push_back('{1'b0, 8'h38, -1, 0});
      exp_q.push_back('{1'b0, 8'h0C, -1, 0});
      exp_q.push_back('{1'b0, 8'h01, -1, 0});
      exp_q.push_back('{1'b0, 8'h06, -1, 0});
`endif
   endtask

   // ---------------- monitor ----------------
   exp_t       cur;
   bit         cur_act = 0;
   int         en_start = 0;
   int         hold_left = 0;
   bit         rdy_pend = 0;
   int         pend_hs = 0;
   int         pend_lat = 0;
   logic       en_prev = 0, rdy_prev = 0, rst_prev = 0;
   logic [8:0] hist1 = '0, hist2 = '0;

   always @(negedge clk) begin
      ncyc++;
      if (!rst_n) begin
         chk("rst_en", lcd_en, 0);
         chk("rst_word", lcd_word, 0);
         chk("rst_rdy", req_rdy, 0);
         chk("rst_busy", busy, 1);
         cur_act   = 0;
         hold_left = 0;
         rdy_pend  = 0;
         en_prev   = 0;
         rdy_prev  = 0;
         rst_prev  = 0;
      end else begin
         chk("word_low", lcd_word[10:0], {lcd_en, lcd_rs, lcd_rw, lcd_data});
         chk("word_high", lcd_word[31:11], {lcd_on, 20'b0});
         chk("rw_zero", lcd_rw, 0);
         chk("lcd_on", lcd_on, 1);
         chk("busy_vs_rdy", busy, !req_rdy);
         if (!rst_prev) chk("rdy_after_rst", req_rdy, INIT_MODE ? 0 : 1);

         if (lcd_en && !en_prev) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               cur      = exp_q.pop_front();
               cur_act  = 1;
               en_start = ncyc;
               chk("pulse_rs", lcd_rs, cur.rs);
               chk("pulse_data", lcd_data, cur.data);
               chk("setup_bus1", hist1, {cur.rs, cur.data});
               chk("setup_bus2", hist2, {cur.rs, cur.data});
               if (cur.hs >= 0) chk("pulse_start", ncyc - cur.hs, P_SETUP + 1);
            end
         end
         if (!lcd_en && en_prev && cur_act) begin
            chk("pulse_width", ncyc - en_start, P_EN);
            hold_left = P_HOLD;
         end
         if (cur_act && (lcd_en || hold_left > 0))
            chk("bus_stable", {lcd_rs, lcd_data}, {cur.rs, cur.data});
         if (cur_act && !lcd_en && hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) begin
               cur_act = 0;
               if (cur.hs >= 0) begin
                  rdy_pend = 1;
                  pend_hs  = cur.hs;
                  pend_lat = cur.lat;
               end
            end
         end

         if (req_rdy && !rdy_prev && rst_prev) begin
            if (rdy_pend) begin
               chk("rdy_latency", ncyc - pend_hs, pend_lat);
               rdy_pend = 0;
            end else begin
`ifdef LCD_INIT_EN
               chk("init_cmds_left", exp_q.size(), 0);
               chk("init_in_flight", cur_act, 0);
`else
               chk("unexpected_rdy", 1, 0);
`endif
            end
         end

         en_prev  = lcd_en;
         rdy_prev = req_rdy;
         rst_prev = 1;
         hist2    = hist1;
         hist1    = {lcd_rs, lcd_data};
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic rs, input logic [7:0] d, input bit keep_vld);
      int unsigned t;
      t        = 0;
      req_vld  = 1'b1;
      req_rs   = rs;
      req_data = d;
      while (!req_rdy && t < 300) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("handshake_timeout", req_rdy, 1);
      if (!req_rdy) begin
         req_vld = 1'b0;
         return;
      end
      exp_q.push_back('{rs, d, ncyc, exp_lat(rs, d)});
      @(negedge clk);
      #1;
      if (!keep_vld) req_vld = 1'b0;
   endtask

   task automatic wait_rdy(input string name);
      int unsigned t;
      t = 0;
      while (!req_rdy && t < 300) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk(name, req_rdy, 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      push_init_cmds();
      repeat (3) begin
         @(negedge clk);
         #1;
      end
      rst_n = 1'b1;
   endtask

   initial begin
      logic       rs;
      logic [7:0] d;
      bit         b2b;
      int unsigned t;

      do_reset();
      @(negedge clk);
      #1;

      // Data write and Clear/Home/boundary commands
      send(1'b1, 8'h41, 0);
      send(1'b0, 8'h01, 0);
      send(1'b0, 8'h02, 0);
      send(1'b0, 8'h03, 0);
      send(1'b0, 8'h00, 0);
      send(1'b0, 8'h04, 0);
      send(1'b1, 8'h01, 0);

      // Back-to-back with vld held high
      send(1'b1, 8'hA5, 1);
      send(1'b0, 8'h5A, 0);

      for (int i = 0; i < 40; i++) begin
         rs  = 1'($urandom_range(0, 1));
         d   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
         b2b = ($urandom_range(0, 2) == 0);
         send(rs, d, b2b);
         if (!b2b) begin
            repeat ($urandom_range(0, 3)) begin
               @(negedge clk);
               #1;
            end
         end
      end
      req_vld = 1'b0;
      wait_rdy("drain_rdy");

      // Reset in the middle of an EN pulse
      send(1'b1, 8'hC3, 0);
      t = 0;
      while (!lcd_en && t < 30) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("pulse_seen", lcd_en, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_pulse_en", lcd_en, 0);
      chk("rst_pulse_word", lcd_word, 0);
      do_reset();
      @(negedge clk);
      #1;
      send(1'b1, 8'h7E, 0);
      send(1'b0, 8'h01, 0);
      wait_rdy("final_rdy");
      repeat (3) begin
         @(negedge clk);
         #1;
      end
      chk("queue_empty", exp_q.size(), 0);
      chk("no_open_transfer", cur_act, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
